// File: rtl/icache_2way_if.sv
// Fetch-side and memory-side signals of the two-way instruction cache.
// The master drives the inputs of the cache; the slave is the cache itself.
interface icache_2way_if #(
    parameter int LINE_W = 64
);
    logic              rdy;
    logic [31:0]       pc_addr;
    logic              flush;
    logic              hit;
    logic [31:0]       ins_out;
    logic              mem_valid;
    logic [LINE_W-1:0] ins_blk;
    logic              mem_en;
    logic [31:0]       addr_to_mem;

    modport master (
        output rdy, pc_addr, flush, mem_valid, ins_blk,
        input  hit, ins_out, mem_en, addr_to_mem
    );

    modport slave (
        input  rdy, pc_addr, flush, mem_valid, ins_blk,
        output hit, ins_out, mem_en, addr_to_mem
    );
endinterface

// File: rtl/icache_2way.sv
// Two-way set-associative instruction cache with LRU replacement,
// whole-cache flush and a captured refill address.
module icache_2way #(
    parameter int ADDR_W   = 18,
    parameter int SET_BITS = 5,
    parameter int OFF_BITS = 1
) (
    input logic          clk,
    input logic          rst,
    icache_2way_if.slave bus
);
    localparam int SETS   = 1 << SET_BITS;
    localparam int LINE_W = 32 << OFF_BITS;
    localparam int LSB    = OFF_BITS + 2;
    localparam int TAG_W  = ADDR_W - SET_BITS - OFF_BITS - 2;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic [SETS-1:0] valid0, valid1, lru;
    logic [TAG_W-1:0]  tag0  [SETS];
    logic [TAG_W-1:0]  tag1  [SETS];
    logic [LINE_W-1:0] data0 [SETS];
    logic [LINE_W-1:0] data1 [SETS];

    logic        mem_en_q, mem_en_d;
    logic [31:0] addr_q, addr_d;
    logic        drop_q, drop_d;

    logic                fill, lru_upd, clr_valid, clr_lru;
    logic [OFF_BITS-1:0] off;
    logic [SET_BITS-1:0] set_idx, fset;
    logic [TAG_W-1:0]    tag_in, ftag;
    logic                m0, m1, hit_way, victim;
    logic [LINE_W-1:0]   line;
    logic                unused_ok;

    assign off     = bus.pc_addr[LSB-1:2];
    assign set_idx = bus.pc_addr[LSB+SET_BITS-1:LSB];
    assign tag_in  = bus.pc_addr[ADDR_W-1:LSB+SET_BITS];
    assign fset    = addr_q[LSB+SET_BITS-1:LSB];
    assign ftag    = addr_q[ADDR_W-1:LSB+SET_BITS];

    assign unused_ok = ^{bus.pc_addr[1:0]};

    // Way 0 takes precedence should both ways ever match.
    assign m0      = valid0[set_idx] && (tag0[set_idx] == tag_in);
    assign m1      = valid1[set_idx] && (tag1[set_idx] == tag_in);
    assign hit_way = !m0;
    assign line    = m0 ? data0[set_idx] : data1[set_idx];

    assign bus.hit         = m0 | m1;
    assign bus.ins_out     = bus.hit ? line[{off, 5'b0} +: 32] : 32'h0;
    assign bus.mem_en      = mem_en_q;
    assign bus.addr_to_mem = addr_q;

    always_comb begin
        victim = lru[fset];
        if (!valid0[fset])
            victim = 1'b0;
        else if (!valid1[fset])
            victim = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else if (bus.rdy)
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_en_d  = mem_en_q;
        addr_d    = addr_q;
        drop_d    = drop_q;
        fill      = 1'b0;
        lru_upd   = 1'b0;
        clr_valid = 1'b0;
        clr_lru   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    clr_valid = 1'b1;
                    clr_lru   = 1'b1;
                end else if (bus.hit) begin
                    lru_upd = 1'b1;
                end else begin
                    addr_d   = {bus.pc_addr[31:LSB], {LSB{1'b0}}};
                    mem_en_d = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                lru_upd = bus.hit;
                if (bus.flush) begin
                    clr_valid = 1'b1;
                    drop_d    = 1'b1;
                end
                if (bus.mem_valid) begin
                    fill     = !drop_q && !bus.flush;
                    mem_en_d = 1'b0;
                    drop_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q <= 1'b0;
            addr_q   <= '0;
            drop_q   <= 1'b0;
            valid0   <= '0;
            valid1   <= '0;
            lru      <= '0;
        end else if (bus.rdy) begin
            mem_en_q <= mem_en_d;
            addr_q   <= addr_d;
            drop_q   <= drop_d;
            if (clr_valid) begin
                valid0 <= '0;
                valid1 <= '0;
            end
            if (clr_lru)
                lru <= '0;
            if (lru_upd)
                lru[set_idx] <= ~hit_way;
            // Fill comes last so its LRU write beats a same-set hit update.
            if (fill) begin
                if (victim)
                    valid1[fset] <= 1'b1;
                else
                    valid0[fset] <= 1'b1;
                lru[fset] <= ~victim;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.rdy && fill) begin
            if (victim) begin
                data1[fset] <= bus.ins_blk;
                tag1[fset]  <= ftag;
            end else begin
                data0[fset] <= bus.ins_blk;
                tag0[fset]  <= ftag;
            end
        end
    end
endmodule

// File: doc/icache_2way.md
# icache_2way

Parametrised two-way set-associative instruction cache between the instruction fetch unit and the memory controller. It replaces the direct-mapped single-line-size design with a configurable set count, line size and valid address width. It adds LRU replacement, a whole-cache flush for `fence.i` and mispredict recovery, and captures the refill address so that PC changes during a refill cannot corrupt the cache.

## Interface

- `ADDR_W`, default 18: number of significant byte-address bits; bits above are ignored for tag compare.
- `SET_BITS`, default 5: sets = 2^SET_BITS.
- `OFF_BITS`, default 1: words per line = 2^OFF_BITS, so LINE_W = 32·2^OFF_BITS.
- Derived `TAG_W` = ADDR_W − SET_BITS − OFF_BITS − 2; must be ≥ 1.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state is frozen.
- `pc_addr` in 32: fetch byte address; bits [1:0] are always 00.
- `flush` in 1: invalidate every line, sampled when `rdy`.
- `hit` out 1: combinational; the word at `pc_addr` is resident.
- `ins_out` out 32: selected word when `hit`, else 0.
- `mem_valid` in 1: one-cycle pulse; `ins_blk` carries the requested line.
- `ins_blk` in LINE_W: refill line; word k occupies bits [32k+31:32k].
- `mem_en` out 1: refill request, held high until `mem_valid`.
- `addr_to_mem` out 32: line-aligned refill address (low OFF_BITS+2 bits zero).

## Operation

- Address split: offset = pc[OFF_BITS+1:2]; set = pc[OFF_BITS+SET_BITS+1:OFF_BITS+2]; tag = pc[ADDR_W-1:OFF_BITS+SET_BITS+2].
- Per set: valid[2], tag[2], data[2], and one `lru` bit naming the way to evict next.
- `hit` = OR over ways of (valid & tag match). Both ways matching cannot occur; if it does, way 0 wins.
- States:
  - IDLE
    - `flush`: clear all valid bits and lru bits; no request.
    - Else if a hit: lru[set] <= ~hitway.
    - Else (miss): latch `req_addr` = line-aligned pc; mem_en <= 1; addr_to_mem <= req_addr; go to WAIT.
  - WAIT
    - `hit` stays live for other resident addresses and updates LRU as in IDLE.
    - Misses are ignored.
    - `flush` clears all valid bits and sets `drop`.
    - On `mem_valid`:
      - If neither `drop` nor a same-cycle `flush` is active: write the line into the victim way of set(req_addr), set valid, write tag(req_addr), and set lru[set] <= ~victim.
      - In all cases: mem_en <= 0; drop <= 0; go to IDLE.
- Victim selection: way 0 if invalid, else way 1 if invalid, else lru[set].
- Fill and flush in the same cycle: flush wins and the line is discarded.
- Fill and hit-LRU update to the same set in the same cycle: the fill update wins.
- `rdy` = 0: no register changes; `mem_valid` is ignored, and the memory controller holds it in that case.
- `rst` overrides `flush`, `rdy` and everything else.

## Timing

- Reset values: mem_en = 0, addr_to_mem = 0, state IDLE, drop = 0, all valid = 0, all lru = 0. The data and tag arrays are not reset.
- A hit is served in the same cycle, with zero latency.
- Miss sensed at edge N (IDLE, rdy): mem_en = 1 and addr_to_mem are valid from N+1.
- `mem_valid` at cycle M: the line is written at edge M. From M+1, mem_en = 0 and `hit` is asserted if the pc is unchanged.
- The earliest next request follows one IDLE cycle after the fill, at M+2.
- `addr_to_mem` holds its value while mem_en is high; it is not cleared on completion.
- Flush takes effect at the clock edge: `hit` is 0 for every address from the following cycle.
- Reset asserted mid-refill: mem_en drops the next cycle. The memory controller is reset by the same `rst`.

## Test plan

- Cold miss: rst, then pc = 0x1004.
  - mem_en = 1 and addr_to_mem = 0x1000 the next cycle.
  - Return mem_valid with ins_blk = {0xBBBBBBBB, 0xAAAAAAAA}: hit = 1 and ins_out = 0xBBBBBBBB the next cycle; pc = 0x1000 gives 0xAAAAAAAA.
- Conflict/LRU (defaults): fill 0x0000, 0x0100 and 0x0200 (same set 0, different tags).
  - After the third fill, 0x0000 misses and 0x0100 and 0x0200 hit.
  - Re-touch 0x0100, then fill 0x0000: 0x0200 is evicted.
- Flush during WAIT: miss 0x2000, pulse flush, then mem_valid.
  - No line is installed: 0x2000 misses again; previously resident 0x0100 misses; mem_en drops after mem_valid.
- PC change during refill: miss 0x3000, move pc to 0x3400 before mem_valid.
  - The line installs under the tag of 0x3000: hit for 0x3000 and miss for 0x3400.
- rdy stall: hold rdy = 0 across a mem_valid pulse and a flush.
  - Nothing changes and mem_en stays 1.
  - Re-pulse mem_valid with rdy = 1: the fill completes.
- Parameter sweep: OFF_BITS = 2, SET_BITS = 3, ADDR_W = 16.
  - pc = 0x000C after a fill of line 0x0000 returns ins_blk[127:96].
  - addr_to_mem low 4 bits are 0.
